// File: rtl/circular_buffer_burst_tx_pkg.sv
// Shared sizing helpers for the wide-to-narrow burst serializer FIFO.
// Optional feature macro: CBUF_CRITICAL_WORD_FIRST_EN (critical-word-first beat order).
package circular_buffer_burst_tx_pkg;

    // Default build configuration.
    localparam int DEF_WIDTH_I = 128;
    localparam int DEF_WIDTH_O = 32;
    localparam int DEF_DEPTH   = 4;

    // Number of narrow beats needed to carry one line.
    function automatic int calc_nbeats(input int width_i, input int width_o);
        return width_i / width_o;
    endfunction

    // Index width for a counter or pointer over n items, never narrower than one bit.
    function automatic int calc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_NBEATS = calc_nbeats(DEF_WIDTH_I, DEF_WIDTH_O);
    localparam int DEF_PTR_W  = calc_width(DEF_DEPTH);
    localparam int DEF_IDX_W  = calc_width(DEF_NBEATS);

    // Beat index within a line for the default configuration.
    typedef logic [DEF_IDX_W-1:0] beat_idx_t;

endpackage

// File: rtl/circular_buffer_burst_tx_line_mem.sv
// Line storage for the burst serializer: DEPTH x WIDTH registers,
// synchronous write, asynchronous read so the current line is visible
// in the same cycle the tail pointer moves onto it.
module cbuf_line_mem
    import circular_buffer_burst_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH_I,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = calc_width(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Capture an accepted line into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/circular_buffer_burst_tx.sv
// Wide-to-narrow burst serializer FIFO: stores whole lines in a circular
// buffer and emits each as a burst of narrow beats, last_o on the final beat.
// Optional feature macro: CBUF_CRITICAL_WORD_FIRST_EN adds start_beat_i and
// emits each line in wrap order starting at its stored beat.
module circular_buffer_burst_tx
    import circular_buffer_burst_tx_pkg::*;
#(
    parameter int CBUFF_WIDTH_I = 128,
    parameter int CBUFF_WIDTH_O = 32,
    parameter int CBUFF_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CBUFF_WIDTH_I-1:0] data_i,
    input  logic                     valid_i,
`ifdef CBUF_CRITICAL_WORD_FIRST_EN
    input  logic [calc_width(calc_nbeats(CBUFF_WIDTH_I, CBUFF_WIDTH_O))-1:0] start_beat_i,
`endif
    output logic                     ready_o,
    output logic [CBUFF_WIDTH_O-1:0] data_o,
    output logic                     valid_o,
    output logic                     last_o,
    input  logic                     ready_i,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int NBEATS = calc_nbeats(CBUFF_WIDTH_I, CBUFF_WIDTH_O);
    localparam int PTR_W  = calc_width(CBUFF_DEPTH);
    localparam int IDX_W  = calc_width(NBEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    generate
        if ((CBUFF_WIDTH_I <= CBUFF_WIDTH_O) || ((CBUFF_WIDTH_I % CBUFF_WIDTH_O) != 0)) begin : g_bad_width
            $error("circular_buffer_burst_tx: CBUFF_WIDTH_I must be a larger multiple of CBUFF_WIDTH_O");
        end
        if ((CBUFF_DEPTH < 2) || ((CBUFF_DEPTH & (CBUFF_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("circular_buffer_burst_tx: CBUFF_DEPTH must be a power of 2 of at least 2");
        end
    endgenerate

`ifdef CBUF_CRITICAL_WORD_FIRST_EN
    localparam int ENTRY_W = CBUFF_WIDTH_I + IDX_W;
`else
    localparam int ENTRY_W = CBUFF_WIDTH_I;
`endif

    logic [PTR_W-1:0]         head_ptr;
    logic [PTR_W-1:0]         tail_ptr;
    logic [PTR_W-1:0]         head_next;
    logic [PTR_W-1:0]         tail_next;
    logic [IDX_W-1:0]         beat_cnt;
    logic [IDX_W-1:0]         cur_idx;
    logic [IDX_W-1:0]         next_idx;
    logic                     full_r;
    logic                     empty_r;
    logic                     push;
    logic                     pop;
    logic                     is_last;
    logic                     line_free;
    logic [ENTRY_W-1:0]       wr_entry;
    logic [ENTRY_W-1:0]       rd_entry;
    logic [CBUFF_WIDTH_I-1:0] rd_line;

    // A push is only taken against the registered full flag, so a line
    // freed in the same cycle cannot be refilled until the next one.
    assign push      = valid_i & ~full_r;
    assign pop       = ~empty_r & ready_i;
    assign line_free = pop & is_last;
    assign head_next = head_ptr + 1'b1;
    assign tail_next = tail_ptr + 1'b1;

`ifdef CBUF_CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0] issue_cnt;
    logic [IDX_W-1:0] rd_start;

    assign wr_entry = {start_beat_i, data_i};
    assign rd_line  = rd_entry[CBUFF_WIDTH_I-1:0];
    assign rd_start = rd_entry[ENTRY_W-1 -: IDX_W];
    // The first beat of a line uses the stored start beat directly, later
    // beats follow beat_cnt; completion is judged by beats issued.
    assign cur_idx  = (issue_cnt == '0) ? rd_start : beat_cnt;
    assign is_last  = (issue_cnt == LAST_IDX);

    // Count beats issued for the current line so last_o lands on the NBEATS-th beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt <= '0;
        end else if (pop) begin
            issue_cnt <= is_last ? '0 : issue_cnt + 1'b1;
        end
    end
`else
    assign wr_entry = data_i;
    assign rd_line  = rd_entry;
    assign cur_idx  = beat_cnt;
    assign is_last  = (beat_cnt == LAST_IDX);
`endif

    assign next_idx = (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;

    cbuf_line_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (CBUFF_DEPTH),
        .PTR_W (PTR_W)
    ) u_line_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_ptr  (head_ptr),
        .wr_data (wr_entry),
        .rd_ptr  (tail_ptr),
        .rd_data (rd_entry)
    );

    // Step through the beats of the line at the tail, restarting at beat 0 after the last.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= is_last ? '0 : next_idx;
        end
    end

    // Advance the pointers on push and line-free and keep the full/empty flags in step.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push) begin
                head_ptr <= head_next;
            end
            if (line_free) begin
                tail_ptr <= tail_next;
            end
            case ({push, line_free})
                2'b10: begin
                    empty_r <= 1'b0;
                    full_r  <= (head_next == tail_ptr);
                end
                2'b01: begin
                    full_r  <= 1'b0;
                    empty_r <= (tail_next == head_ptr);
                end
                default: begin
                    full_r  <= full_r;
                    empty_r <= empty_r;
                end
            endcase
        end
    end

    assign ready_o = ~full_r;
    assign valid_o = ~empty_r;
    assign last_o  = ~empty_r & is_last;
    assign empty_o = empty_r;
    assign full_o  = full_r;
    assign data_o  = rd_line[int'(cur_idx) * CBUFF_WIDTH_O +: CBUFF_WIDTH_O];

endmodule

// File: tb/tb_circular_buffer_burst_tx.sv
// Self-checking bench for circular_buffer_burst_tx: a directed vector table,
// hand-written corner sequences and a randomized run, all compared against a
// queue-based model of the line buffer.
// Optional feature macro: CBUF_CRITICAL_WORD_FIRST_EN.
module tb_circular_buffer_burst_tx;
    import circular_buffer_burst_tx_pkg::*;

    localparam int WI    = 128;
    localparam int WO    = 32;
    localparam int DEPTH = 4;
    localparam int NB    = WI / WO;
    localparam logic [WI-1:0] LINE_A = 128'h44444444_33333333_22222222_11111111;

    logic          clk = 1'b0;
    logic          reset;
    logic [WI-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [WO-1:0] data_o;
    logic          valid_o;
    logic          last_o;
    logic          ready_i;
    logic          empty_o;
    logic          full_o;
`ifdef CBUF_CRITICAL_WORD_FIRST_EN
    beat_idx_t     start_beat_i;
`endif

    int vectors = 0;
    int errors  = 0;

    circular_buffer_burst_tx #(
        .CBUFF_WIDTH_I (WI),
        .CBUFF_WIDTH_O (WO),
        .CBUFF_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_i       (data_i),
        .valid_i      (valid_i),
`ifdef CBUF_CRITICAL_WORD_FIRST_EN
        .start_beat_i (start_beat_i),
`endif
        .ready_o      (ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .last_o       (last_o),
        .ready_i      (ready_i),
        .empty_o      (empty_o),
        .full_o       (full_o)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored lines plus the number of beats
    // already delivered from the head line.
    typedef struct {
        logic [WI-1:0] line;
        int            start;
    } entry_t;

    entry_t mq[$];
    int     m_issued = 0;
    bit     m_ready;
    bit     m_valid;
    bit     m_last;
    bit     m_push;
    bit     m_pop;
    int     m_start;
    entry_t m_new;

    // Model update at each rising edge from the inputs in force before the edge.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_issued = 0;
        end else begin
            m_ready = (mq.size() < DEPTH);
            m_valid = (mq.size() > 0);
            m_last  = m_valid && (m_issued == NB - 1);
            m_push  = valid_i && m_ready;
            m_pop   = m_valid && ready_i;
            m_start = 0;
`ifdef CBUF_CRITICAL_WORD_FIRST_EN
            m_start = int'(start_beat_i);
`endif
            if (m_pop) begin
                if (m_last) begin
                    void'(mq.pop_front());
                    m_issued = 0;
                end else begin
                    m_issued = m_issued + 1;
                end
            end
            if (m_push) begin
                m_new.line  = data_i;
                m_new.start = m_start;
                mq.push_back(m_new);
            end
        end
    end

    // Compare every DUT output against what the model says should be visible now.
    task automatic check_model(input string tag);
        logic          ev;
        logic          el;
        logic [WO-1:0] ed;
        logic [WO-1:0] gd;
        int            idx;
        ev  = (mq.size() > 0);
        el  = ev && (m_issued == NB - 1);
        ed  = '0;
        if (ev) begin
            idx = (mq[0].start + m_issued) % NB;
            ed  = mq[0].line[idx*WO +: WO];
        end
        gd = valid_o ? data_o : '0;
        vectors++;
        if ({valid_o, last_o, ready_o, empty_o, full_o, gd} !==
            {ev, el, (mq.size() < DEPTH), (mq.size() == 0), (mq.size() == DEPTH), ed}) begin
            errors++;
            $display("[TB] FAIL model %s: got v=%0b l=%0b r=%0b e=%0b f=%0b d=%h, expected v=%0b l=%0b r=%0b e=%0b f=%0b d=%h",
                     tag, valid_o, last_o, ready_o, empty_o, full_o, gd,
                     ev, el, (mq.size() < DEPTH), (mq.size() == 0), (mq.size() == DEPTH), ed);
        end
    endtask

    // Single named comparison of a value against a bench-computed expectation.
    task automatic check_output(input string name, input logic [WO-1:0] got, input logic [WO-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Advance one clock, then compare outputs once they have settled.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic apply_stimulus(input logic rst, input logic vin, input logic [WI-1:0] din, input logic rdy);
        reset   = rst;
        valid_i = vin;
        data_i  = din;
        ready_i = rdy;
    endtask

    task automatic do_reset();
        apply_stimulus(1'b1, 1'b0, '0, 1'b0);
        tick("reset");
        reset = 1'b0;
    endtask

    typedef struct {
        logic          rst;
        logic          vin;
        logic [WI-1:0] din;
        logic          rdy;
        logic          ev;
        logic          el;
        logic          er;
        logic          ee;
        logic          ef;
        logic [WO-1:0] ed;
    } vec_t;

    vec_t          vecs[6];
    logic [WI-1:0] lines[5];
    logic [WO-1:0] held;
    logic          held_last;

    initial begin
        apply_stimulus(1'b1, 1'b0, '0, 1'b0);
`ifdef CBUF_CRITICAL_WORD_FIRST_EN
        start_beat_i = '0;
`endif

        // Directed single-line burst: expected outputs after each edge.
        vecs[0] = '{1'b1, 1'b0, '0,     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, LINE_A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h11111111};
        vecs[2] = '{1'b0, 1'b0, '0,     1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h22222222};
        vecs[3] = '{1'b0, 1'b0, '0,     1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h33333333};
        vecs[4] = '{1'b0, 1'b0, '0,     1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h44444444};
        vecs[5] = '{1'b0, 1'b0, '0,     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].vin, vecs[i].din, vecs[i].rdy);
            tick($sformatf("vec%0d", i));
            vectors++;
            if ({valid_o, last_o, ready_o, empty_o, full_o, (valid_o ? data_o : 32'h0)} !==
                {vecs[i].ev, vecs[i].el, vecs[i].er, vecs[i].ee, vecs[i].ef, vecs[i].ed}) begin
                errors++;
                $display("[TB] FAIL table vec%0d: got v=%0b l=%0b r=%0b e=%0b f=%0b d=%h, expected v=%0b l=%0b r=%0b e=%0b f=%0b d=%h",
                         i, valid_o, last_o, ready_o, empty_o, full_o, data_o,
                         vecs[i].ev, vecs[i].el, vecs[i].er, vecs[i].ee, vecs[i].ef, vecs[i].ed);
            end
        end

        // Fill to full with the sink stalled, try a fifth push, then drain.
        for (int i = 0; i < 5; i++) begin
            lines[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, lines[i], 1'b0);
            tick("fill");
        end
        check_output("full_when_4", {31'b0, full_o}, 32'd1);
        check_output("not_ready_when_full", {31'b0, ready_o}, 32'd0);
        apply_stimulus(1'b0, 1'b1, lines[4], 1'b0);
        tick("push_ignored");
        apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            tick("drain");
            if (k == 3) check_output("ready_still_low", {31'b0, ready_o}, 32'd0);
            if (k == 4) check_output("ready_after_line0", {31'b0, ready_o}, 32'd1);
            if (k == 16) check_output("empty_after_drain", {31'b0, empty_o}, 32'd1);
        end

        // Stall in the middle of a burst: ready_i 1,0,0,1.
        do_reset();
        apply_stimulus(1'b0, 1'b1, LINE_A, 1'b0);
        tick("stall_push");
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick("stall_b0");
        ready_i = 1'b0;
        held      = data_o;
        held_last = last_o;
        tick("stall_1");
        tick("stall_2");
        check_output("stall_data_held", data_o, held);
        check_output("stall_last_held", {31'b0, last_o}, {31'b0, held_last});
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) tick("stall_resume");

        // Full buffer; push offered on the cycle the last beat of line 0 pops.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, lines[i], 1'b0);
            tick("wrap_fill");
        end
        apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 3; k++) tick("wrap_beats");
        check_output("last_beat_line0", {31'b0, last_o}, 32'd1);
        apply_stimulus(1'b0, 1'b1, lines[4], 1'b1);
        tick("wrap_reject");
        check_output("ready_after_free", {31'b0, ready_o}, 32'd1);
        tick("wrap_accept");
        valid_i = 1'b0;
        check_output("refull_after_wrap", {31'b0, full_o}, 32'd1);
        for (int k = 0; k < 17; k++) tick("wrap_drain");

        // Reset during beat 2 of a line with two lines queued.
        do_reset();
        apply_stimulus(1'b0, 1'b1, lines[0], 1'b0);
        tick("rst_fill0");
        data_i = lines[1];
        tick("rst_fill1");
        apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        tick("rst_b1");
        tick("rst_b2");
        reset = 1'b1;
        tick("rst_mid");
        check_output("rst_valid_low", {31'b0, valid_o}, 32'd0);
        check_output("rst_empty", {31'b0, empty_o}, 32'd1);
        check_output("rst_ready", {31'b0, ready_o}, 32'd1);
        apply_stimulus(1'b0, 1'b1, LINE_A, 1'b0);
        tick("rst_repush");
        valid_i = 1'b0;
        check_output("rst_restart_beat0", data_o, 32'h11111111);
        ready_i = 1'b1;
        for (int k = 0; k < 5; k++) tick("rst_drain");

`ifdef CBUF_CRITICAL_WORD_FIRST_EN
        // Critical word first: start beat 2 gives beats 2,3,0,1.
        do_reset();
        start_beat_i = 2'd2;
        apply_stimulus(1'b0, 1'b1, LINE_A, 1'b1);
        tick("cwf_push");
        valid_i = 1'b0;
        check_output("cwf_first", data_o, 32'h33333333);
        tick("cwf_b1");
        tick("cwf_b2");
        tick("cwf_b3");
        check_output("cwf_last_data", data_o, 32'h22222222);
        check_output("cwf_last_flag", {31'b0, last_o}, 32'd1);
        tick("cwf_done");
`endif

        // Randomized traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            apply_stimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0),
                           {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) != 0));
`ifdef CBUF_CRITICAL_WORD_FIRST_EN
            start_beat_i = beat_idx_t'($urandom_range(0, NB - 1));
`endif
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/circular_buffer_burst_tx.md
Name: circular_buffer_burst_tx

Overview:
Wide-to-narrow burst serializer FIFO. It is the transmit-side counterpart of the interconnect's narrow-to-wide packing buffer.
- Accepts whole cache lines (CBUFF_WIDTH_I bits) on a valid/ready push port.
- Stores them in a power-of-2 circular buffer.
- Emits each line as an AXI-style beat burst (CBUFF_WIDTH_O bits per beat) with last_o on the final beat.
- Sits between the coherence/line logic and the AXI R (or W) channel drivers.

Parameters:
- CBUFF_WIDTH_I, 128, line width in bits; must be greater than CBUFF_WIDTH_O and a multiple of it (elaboration $error otherwise).
- CBUFF_WIDTH_O, 32, beat width in bits.
- CBUFF_DEPTH, 4, number of line entries; must be a power of 2 (elaboration $error otherwise).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- data_i  in  CBUFF_WIDTH_I  line to enqueue.
- valid_i  in  1  line push request.
- ready_o  out  1  buffer can accept a line (~full).
- data_o  out  CBUFF_WIDTH_O  current beat.
- valid_o  out  1  beat valid (~empty).
- last_o  out  1  current beat is the final beat of its line.
- ready_i  in  1  downstream accepts beat.
- empty_o  out  1  no line stored.
- full_o  out  1  CBUFF_DEPTH lines stored.

Behaviour:
- Definitions:
  - NBEATS = CBUFF_WIDTH_I/CBUFF_WIDTH_O.
  - Pointers: head_ptr, tail_ptr, $clog2(CBUFF_DEPTH) bits, wrap naturally.
  - beat_cnt: $clog2(NBEATS) bits.
- Reset (reset=1 at posedge): head=tail=0, beat_cnt=0, full_r=0, empty_r=1.
  - Outputs after reset: ready_o=1, valid_o=0, last_o=0, empty_o=1, full_o=0.
  - Reset mid-burst discards all stored lines and any partial burst.
- Push: push = valid_i & ready_o.
  - Writes data_i at head_ptr; head increments.
  - ready_o = ~full_r, registered. No push while full, even if a line is freed in the same cycle.
- Beat output:
  - valid_o = ~empty_r.
  - data_o = mem[tail_ptr][beat_cnt*CBUFF_WIDTH_O +: CBUFF_WIDTH_O].
  - last_o = valid_o & (beat_cnt == NBEATS-1).
  - A line pushed at cycle N presents its first beat with valid_o=1 at cycle N+1.
- Pop beat: pop = valid_o & ready_i.
  - If not last: beat_cnt++.
  - If last: beat_cnt=0, tail++ (line freed).
- Stall: while valid_o & ~ready_i, data_o, last_o and valid_o are held stable. No retraction.
- Flags, by event:
  - Push only: empty_next=0; full_next=(head_next==tail).
  - Line-free only: full_next=0; empty_next=(tail_next==head).
  - Push and line-free in the same cycle: both pointers advance, flags unchanged.
  - Non-last beat pop: flags unchanged.
- Back-to-back lines: the first beat of the next line follows the last beat of the previous line with no bubble.
- Throughput: 1 beat/cycle sustained. A line is accepted every NBEATS cycles at steady state.

Optional Feature:
Macro CBUF_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Adds input start_beat_i [$clog2(NBEATS)-1:0], stored alongside each line.
  - On the first beat of a line, beat_cnt loads the stored start_beat.
  - Beats are emitted in wrap order, e.g. NBEATS=4, start=2 gives 2,3,0,1.
  - last_o is asserted on the NBEATS-th beat, tracked with a separate issued-beat counter.
- Not defined: port absent; beats always emitted in order 0..NBEATS-1.

Decomposition:
- param_pkg holds:
  - the NBEATS-derived localparam helpers (beat count, pointer width, beat-index width);
  - a typedef for the beat index.
- One sub-module, cbuf_line_mem:
  - CBUFF_DEPTH x CBUFF_WIDTH_I register array.
  - Synchronous write port, asynchronous read port at tail_ptr.
  - The top level does the beat slicing.

Test Plan:
- Reset, then push line 0x44444444_33333333_22222222_11111111 with ready_i=1 -> valid_o next cycle; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles; last_o only on 4th; empty_o=1 afterwards.
- Push 4 lines with ready_i=0 -> full_o=1, ready_o=0; a 5th valid_i is ignored; then drain -> 16 beats in push order, no bubbles; ready_o rises the cycle after the 4th beat of line 0.
- ready_i toggled 1,0,0,1 during a burst -> data_o/last_o held during stall; no beat lost or duplicated.
- Full buffer; on the cycle the last beat of line 0 pops, also assert valid_i -> push rejected (ready_o=0); the next cycle push is accepted; pointer wrap from 3 to 0 is correct.
- Assert reset during beat 2 of a line with 2 lines queued -> next cycle valid_o=0, empty_o=1, ready_o=1; a subsequent push restarts at beat 0.
- With CBUF_CRITICAL_WORD_FIRST_EN, start_beat_i=2 -> beats 0x33333333, 0x44444444, 0x11111111, 0x22222222; last_o on 0x22222222.
